// File: rtl/axi4_cdc_pkg.sv
// Shared definitions for the 39-bit AXI4 write CDC FIFO word stream (packer and unpacker).
package axi4_cdc_pkg;

  localparam int unsigned FIFO_W    = 39;
  localparam int unsigned TYPE_W    = 2;
  localparam int unsigned PAYLOAD_W = FIFO_W - TYPE_W;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STRB_W   = 4;
  localparam int unsigned LEN_W    = 8;
  localparam int unsigned SIZE_W   = 3;
  localparam int unsigned BURST_W  = 2;
  localparam int unsigned ID_MAX_W = 5;

  // Payload field offsets
  localparam int unsigned HDR0_ID_LSB    = 32;
  localparam int unsigned HDR1_BURST_LSB = 24;
  localparam int unsigned HDR1_SIZE_LSB  = 26;
  localparam int unsigned HDR1_LEN_LSB   = 29;
  localparam int unsigned DATA_STRB_LSB  = 32;
  localparam int unsigned DATA_LAST_BIT  = 36;

  typedef enum logic [TYPE_W-1:0] {
    WORD_DATA = 2'b01,
    WORD_HDR0 = 2'b10,
    WORD_HDR1 = 2'b11
  } word_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR0 = 2'd1,
    ST_HDR1 = 2'd2,
    ST_DATA = 2'd3
  } state_e;

  // Captured AW request; id is zero-extended to the widest legal ID
  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [ADDR_W-1:0]   addr;
    logic [LEN_W-1:0]    len;
    logic [SIZE_W-1:0]   size;
    logic [BURST_W-1:0]  burst;
  } aw_req_t;

  function automatic logic [FIFO_W-1:0] pack_word(word_type_e kind, logic [PAYLOAD_W-1:0] payload);
    return {kind, payload};
  endfunction

endpackage

// File: rtl/axi4_cdc_wr_packer_if.sv
// AXI4 AW/W inport plus CDC FIFO push port of the write-side packer.
interface axi4_cdc_wr_packer_if #(
  parameter int unsigned ID_W = 4
);
  import axi4_cdc_pkg::*;

  logic                 inport_awvalid_i;
  logic [ADDR_W-1:0]    inport_awaddr_i;
  logic [ID_W-1:0]      inport_awid_i;
  logic [LEN_W-1:0]     inport_awlen_i;
  logic [SIZE_W-1:0]    inport_awsize_i;
  logic [BURST_W-1:0]   inport_awburst_i;
  logic                 inport_awready_o;
  logic                 inport_wvalid_i;
  logic [DATA_W-1:0]    inport_wdata_i;
  logic [STRB_W-1:0]    inport_wstrb_i;
  logic                 inport_wlast_i;
  logic                 inport_wready_o;
  logic                 fifo_push_o;
  logic [FIFO_W-1:0]    fifo_data_o;
  logic                 fifo_full_i;

  modport master (
    output inport_awvalid_i, inport_awaddr_i, inport_awid_i, inport_awlen_i,
           inport_awsize_i, inport_awburst_i, inport_wvalid_i, inport_wdata_i,
           inport_wstrb_i, inport_wlast_i, fifo_full_i,
    input  inport_awready_o, inport_wready_o, fifo_push_o, fifo_data_o
  );

  modport slave (
    input  inport_awvalid_i, inport_awaddr_i, inport_awid_i, inport_awlen_i,
           inport_awsize_i, inport_awburst_i, inport_wvalid_i, inport_wdata_i,
           inport_wstrb_i, inport_wlast_i, fifo_full_i,
    output inport_awready_o, inport_wready_o, fifo_push_o, fifo_data_o
  );

endinterface

// File: rtl/axi4_cdc_wr_packer.sv
// Serialises an AXI4 AW + W burst into HDR0, HDR1, DATA... words for the write-domain CDC FIFO.
// Optional macro AXI4_WR_PACKER_LEN_CHECK_EN frames bursts on awlen and flags wlast mismatches.
module axi4_cdc_wr_packer
  import axi4_cdc_pkg::*;
#(
  parameter int unsigned ID_W = 4
) (
  input  logic                 wr_clk_i,
  input  logic                 wr_rst_i,
  axi4_cdc_wr_packer_if.slave  bus,
  output logic                 busy_o,
  output logic                 err_o
);

  state_e                 state;
  state_e                 state_nxt;
  aw_req_t                aw_q;
  logic [LEN_W-1:0]       beat_cnt;
  logic [ID_W-1:0]        awid;
  logic                   beat_c;
  logic                   last_c;
  logic [PAYLOAD_W-1:0]   hdr0_payload_c;
  logic [PAYLOAD_W-1:0]   hdr1_payload_c;
  logic [PAYLOAD_W-1:0]   data_payload_c;

  assign awid   = bus.inport_awid_i;
  assign beat_c = (state == ST_DATA) && bus.inport_wvalid_i && !bus.fifo_full_i;

`ifdef AXI4_WR_PACKER_LEN_CHECK_EN
  logic len_hit_c;

  // Framing follows the captured awlen, not the master's wlast
  assign len_hit_c = (beat_cnt == aw_q.len);
  assign last_c    = len_hit_c;

  always_ff @(posedge wr_clk_i or posedge wr_rst_i) begin
    if (wr_rst_i) begin
      err_o <= 1'b0;
    end else if (beat_c && (bus.inport_wlast_i != len_hit_c)) begin
      err_o <= 1'b1;
    end
  end
`else
  assign last_c = bus.inport_wlast_i;
  assign err_o  = 1'b0;
`endif

  // State register; busy is registered alongside it
  always_ff @(posedge wr_clk_i or posedge wr_rst_i) begin
    if (wr_rst_i) begin
      state  <= ST_IDLE;
      busy_o <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_o <= (state_nxt != ST_IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (bus.inport_awvalid_i) state_nxt = ST_HDR0;
      ST_HDR0: if (!bus.fifo_full_i)     state_nxt = ST_HDR1;
      ST_HDR1: if (!bus.fifo_full_i)     state_nxt = ST_DATA;
      ST_DATA: if (beat_c && last_c)     state_nxt = ST_IDLE;
      default:                           state_nxt = ST_IDLE;
    endcase
  end

  // AW capture and beat counter
  always_ff @(posedge wr_clk_i or posedge wr_rst_i) begin
    if (wr_rst_i) begin
      aw_q     <= '0;
      beat_cnt <= '0;
    end else if ((state == ST_IDLE) && bus.inport_awvalid_i) begin
      aw_q     <= '{id:    ID_MAX_W'(awid),
                    addr:  bus.inport_awaddr_i,
                    len:   bus.inport_awlen_i,
                    size:  bus.inport_awsize_i,
                    burst: bus.inport_awburst_i};
      beat_cnt <= '0;
    end else if (beat_c) begin
      beat_cnt <= beat_cnt + LEN_W'(1);
    end
  end

  assign hdr0_payload_c = (PAYLOAD_W'(aw_q.id) << HDR0_ID_LSB)
                        | PAYLOAD_W'(aw_q.addr);
  assign hdr1_payload_c = (PAYLOAD_W'(aw_q.len)   << HDR1_LEN_LSB)
                        | (PAYLOAD_W'(aw_q.size)  << HDR1_SIZE_LSB)
                        | (PAYLOAD_W'(aw_q.burst) << HDR1_BURST_LSB);
  assign data_payload_c = (PAYLOAD_W'(last_c)             << DATA_LAST_BIT)
                        | (PAYLOAD_W'(bus.inport_wstrb_i) << DATA_STRB_LSB)
                        | PAYLOAD_W'(bus.inport_wdata_i);

  // Output decode: push/data/wready are combinational so a W beat costs no extra cycle
  always_comb begin
    bus.inport_awready_o = 1'b0;
    bus.inport_wready_o  = 1'b0;
    bus.fifo_push_o      = 1'b0;
    bus.fifo_data_o      = '0;
    unique case (state)
      ST_IDLE: bus.inport_awready_o = 1'b1;
      ST_HDR0: begin
        bus.fifo_push_o = 1'b1;
        bus.fifo_data_o = pack_word(WORD_HDR0, hdr0_payload_c);
      end
      ST_HDR1: begin
        bus.fifo_push_o = 1'b1;
        bus.fifo_data_o = pack_word(WORD_HDR1, hdr1_payload_c);
      end
      ST_DATA: begin
        bus.inport_wready_o = !bus.fifo_full_i;
        bus.fifo_push_o     = bus.inport_wvalid_i;
        if (bus.inport_wvalid_i) bus.fifo_data_o = pack_word(WORD_DATA, data_payload_c);
      end
      default: ;
    endcase
  end

endmodule
